// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN node family: controller state type and default widths.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH = 16;
  localparam int KPN_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_FORWARD = 2'd2
  } kpn_state_e;

endpackage

// File: rtl/kpn_token_counter.sv
// 16-bit token counter with synchronous clear and enable; wraps 0xFFFF -> 0x0000.
module kpn_token_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/kpn_delay_controller.sv
// KPN delay node: injects delay_cfg initial tokens downstream, then forwards
// upstream tokens with zero latency until stopped.
module kpn_delay_controller
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int CNT_WIDTH  = KPN_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  delay_cfg,
  input  logic [DATA_WIDTH-1:0] init_value,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_full,
  output logic                  out_wr,
  output logic                  busy,
  output logic                  preload_done,
  output logic [15:0]           token_count
);

  kpn_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic [DATA_WIDTH-1:0] init_reg_q, init_reg_d;
  logic                  preload_done_q, preload_done_d;
  logic                  cnt_clr, cnt_en;

  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    init_reg_d     = init_reg_q;
    preload_done_d = preload_done_q;
    in_rd          = 1'b0;
    out_wr         = 1'b0;
    out_data       = '0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // start has priority over a simultaneous stop here
        if (start) begin
          remain_d   = delay_cfg;
          init_reg_d = init_value;
          cnt_clr    = 1'b1;
          if (delay_cfg != '0) begin
            state_d        = ST_PRELOAD;
            preload_done_d = 1'b0;
          end else begin
            state_d        = ST_FORWARD;
            preload_done_d = 1'b1;
          end
        end
      end
      ST_PRELOAD: begin
        out_data = init_reg_q;
        out_wr   = !out_full;
        if (out_wr) begin
          remain_d = remain_q - 1'b1;
        end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (out_wr && remain_q == CNT_WIDTH'(1)) begin
          state_d        = ST_FORWARD;
          preload_done_d = 1'b1;
        end
      end
      ST_FORWARD: begin
        in_rd    = !in_empty && !out_full;
        out_wr   = in_rd;
        out_data = in_data;
        cnt_en   = in_rd;
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      remain_q       <= '0;
      init_reg_q     <= '0;
      preload_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      init_reg_q     <= init_reg_d;
      preload_done_q <= preload_done_d;
    end
  end

  kpn_token_counter u_token_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (token_count)
  );

  assign busy         = (state_q != ST_IDLE);
  assign preload_done = preload_done_q;

endmodule

// File: tb/tb_kpn_delay_controller.sv
// Randomized bench for kpn_delay_controller against a queue-based session model.
module tb_kpn_delay_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  delay_cfg = '0;
  logic [15:0] init_value = '0;
  logic [15:0] in_data = '0;
  logic        in_empty = 1'b1;
  logic        in_rd;
  logic [15:0] out_data;
  logic        out_full = 1'b0;
  logic        out_wr;
  logic        busy;
  logic        preload_done;
  logic [15:0] token_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Session model: phase 0=idle, 1=emitting initial tokens, 2=forwarding
  int          ph = 0;
  int          m_pre = 0;
  logic [15:0] m_init = '0;
  logic [15:0] m_cnt = '0;
  logic        m_done = 1'b0;
  int          pre_pushes = 0;
  logic [15:0] up_q[$];

  always #5 clk = ~clk;

  kpn_delay_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .delay_cfg    (delay_cfg),
    .init_value   (init_value),
    .in_data      (in_data),
    .in_empty     (in_empty),
    .in_rd        (in_rd),
    .out_data     (out_data),
    .out_full     (out_full),
    .out_wr       (out_wr),
    .busy         (busy),
    .preload_done (preload_done),
    .token_count  (token_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a rising edge; drives one cycle, checks, advances the model.
  task automatic cycle(input bit st, input bit sp, input logic [3:0] cfg,
                       input logic [15:0] iv, input bit emp, input bit full);
    bit en;
    #1;
    while (up_q.size() < 8) up_q.push_back(16'($urandom));
    start = st; stop = sp; delay_cfg = cfg; init_value = iv;
    out_full = full; in_empty = emp; in_data = up_q[0];
    #1;
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("preload_done", 32'(preload_done), 32'(m_done));
    chk("token_count", 32'(token_count), 32'(m_cnt));
    en = 1'b0;
    case (ph)
      0: begin
        chk("idle_out_wr", 32'(out_wr), 32'd0);
        chk("idle_in_rd", 32'(in_rd), 32'd0);
        chk("idle_out_data", 32'(out_data), 32'd0);
      end
      1: begin
        en = !full;
        chk("pre_out_wr", 32'(out_wr), 32'(en));
        chk("pre_in_rd", 32'(in_rd), 32'd0);
        if (en) chk("pre_out_data", 32'(out_data), 32'(m_init));
        if (out_wr) pre_pushes++;
      end
      default: begin
        en = !emp && !full;
        chk("fwd_out_wr", 32'(out_wr), 32'(en));
        chk("fwd_in_rd", 32'(in_rd), 32'(en));
        if (en) chk("fwd_out_data", 32'(out_data), 32'(up_q[0]));
      end
    endcase
    if (ph == 0) begin
      if (st) begin
        m_init = iv; m_cnt = '0; m_pre = int'(cfg);
        if (cfg == 0) begin ph = 2; m_done = 1'b1; end
        else begin ph = 1; m_done = 1'b0; end
      end
    end else begin
      if (ph == 1 && en) begin
        m_pre--;
        if (m_pre == 0 && !sp) begin ph = 2; m_done = 1'b1; end
      end else if (ph == 2 && en) begin
        void'(up_q.pop_front());
        m_cnt++;
      end
      if (sp) ph = 0;
    end
    @(posedge clk);
  endtask

  // Called on a rising edge; asserts reset between edges and checks its immediate effect.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_in_rd", 32'(in_rd), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_token_count", 32'(token_count), 32'd0);
    chk("rst_preload_done", 32'(preload_done), 32'd0);
    ph = 0; m_cnt = '0; m_done = 1'b0; m_pre = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    do_reset();
    idle(2);

    // Three zero-valued initial tokens, then pass-through
    pre_pushes = 0;
    cycle(1, 0, 4'd3, 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);
    chk("cfg3_init_pushes", 32'(pre_pushes), 32'd3);
    cycle(0, 1, 4'd0, 16'd0, 0, 0);
    idle(2);

    // Zero delay goes straight to forwarding
    cycle(1, 0, 4'd0, 16'h1234, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);
    cycle(0, 1, 4'd0, 16'd0, 1, 0);
    idle(1);

    // Downstream full during preload
    pre_pushes = 0;
    cycle(1, 0, 4'd2, 16'hA5A5, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 4'd0, 16'd0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);
    chk("cfg2_init_pushes", 32'(pre_pushes), 32'd2);
    cycle(0, 1, 4'd0, 16'd0, 0, 0);
    idle(1);

    // Random stalls on both sides over a long forwarding run
    cycle(1, 0, 4'($urandom_range(0, 15)), 16'($urandom), 0, 0);
    for (int i = 0; i < 1000; i++)
      cycle(0, 0, 4'd0, 16'd0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    cycle(0, 1, 4'd0, 16'd0, 1, 1);
    idle(1);

    // Stop after one of four initial tokens; restart with start+stop together
    pre_pushes = 0;
    cycle(1, 0, 4'd4, 16'h0F0F, 0, 0);
    cycle(0, 0, 4'd0, 16'd0, 0, 0);
    cycle(0, 1, 4'd0, 16'd0, 0, 1);
    chk("abort_init_pushes", 32'(pre_pushes), 32'd1);
    idle(2);
    cycle(1, 1, 4'd1, 16'h7777, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);

    // Reset in the middle of forwarding, then a normal session
    do_reset();
    idle(1);
    cycle(1, 0, 4'd1, 16'hBEEF, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0);
    cycle(0, 1, 4'd0, 16'd0, 0, 0);
    idle(1);

    // Counter wrap after 65535 forwarded tokens
    cycle(1, 0, 4'd0, 16'd0, 1, 0);
    #1;
    start = 1'b0; stop = 1'b0; in_empty = 1'b0; out_full = 1'b0; in_data = 16'h5A5A;
    repeat (65535) @(posedge clk);
    m_cnt = 16'hFFFF;
    #2;
    chk("wrap_preset", 32'(token_count), 32'h0000_FFFF);
    @(posedge clk);
    m_cnt = 16'h0000;
    #2;
    chk("wrap_zero", 32'(token_count), 32'h0000_0000);
    chk("wrap_done", 32'(preload_done), 32'd1);
    up_q.delete();
    @(posedge clk);
    m_cnt = 16'h0001;
    cycle(0, 1, 4'd0, 16'd0, 1, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kpn_delay_controller.md
KPN_DELAY_CONTROLLER -- requirements
Module: kpn_delay_controller

Interface
REQ-001 Parameter DATA_WIDTH, 16: token width in bits.
REQ-002 Parameter CNT_WIDTH, 4: width of delay_cfg; maximum preload depth is 2^CNT_WIDTH-1.
REQ-003 One clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins a session (honoured only in IDLE).
REQ-005 stop  in  1  level; ends a session at the next clk edge (PRELOAD or FORWARD).
REQ-006 delay_cfg  in  CNT_WIDTH  number of initial tokens; sampled on an accepted start.
REQ-007 init_value  in  DATA_WIDTH  value of each initial token; sampled on an accepted start.
REQ-008 in_data  in  DATA_WIDTH  head of the upstream first-word-fall-through FIFO; valid while in_empty=0.
REQ-009 in_empty  in  1  upstream FIFO empty.
REQ-010 in_rd  out  1  pop upstream FIFO this cycle.
REQ-011 out_data  out  DATA_WIDTH  token presented to the downstream FIFO.
REQ-012 out_full  in  1  downstream FIFO full.
REQ-013 out_wr  out  1  push out_data downstream this cycle.
REQ-014 busy  out  1  high when state is not IDLE.
REQ-015 preload_done  out  1  high from entry into FORWARD until the next accepted start.
REQ-016 token_count  out  16  count of tokens forwarded in FORWARD since the last accepted start.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, PRELOAD, FORWARD.
REQ-018 IDLE: in_rd=0, out_wr=0, out_data=0; on start=1, latch delay_cfg into remain and init_value into init_reg, clear token_count and preload_done, then go to PRELOAD if delay_cfg!=0, else go to FORWARD.
REQ-019 PRELOAD: out_data=init_reg, out_wr=!out_full, in_rd=0; each cycle with out_wr=1, decrement remain.
REQ-020 PRELOAD SHALL go to FORWARD on the edge where out_wr=1 and remain=1; while out_full=1, state and remain SHALL hold.
REQ-021 FORWARD: in_rd=out_wr=!in_empty && !out_full, out_data=in_data (combinational, zero latency).
REQ-022 Each FORWARD cycle with out_wr=1 SHALL increment token_count, wrapping 0xFFFF->0x0000.
REQ-023 stop=1 in PRELOAD or FORWARD SHALL move the FSM to IDLE at that edge. A transfer enabled in the same cycle SHALL complete and be counted. A partially completed preload is abandoned.
REQ-024 start SHALL be ignored outside IDLE. If start and stop are high together in IDLE, start SHALL win.
REQ-025 In FORWARD, in_empty=1 and out_full=1 SHALL each independently stall with no pop and no push. No token SHALL be lost or duplicated.
REQ-026 token_count and preload_done SHALL hold their values in IDLE until the next accepted start.
REQ-027 The total number of initial tokens pushed in one session SHALL equal the latched delay_cfg, unless stop aborts the session.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, remain=0, init_reg=0, token_count=0, preload_done=0, in_rd=0, out_wr=0, out_data=0, busy=0.
REQ-029 Reset asserted mid-session SHALL abandon the session. After release, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 The shared package kpn_pkg SHALL hold the state enum type and the default DATA_WIDTH/CNT_WIDTH constants.
REQ-031 token_count SHALL be implemented in one sub-module, kpn_token_counter: 16-bit, with clear, enable and wrap; it is reusable by the other KPN nodes.

Verification
REQ-032 Reset, then start with delay_cfg=3, init_value=0x0000, out_full=0, in_empty=0 -> three pushes of 0x0000, then in_data passes through; preload_done rises on the 4th push cycle.
REQ-033 delay_cfg=0, start -> FORWARD on the next cycle; the first push is in_data; preload_done=1 immediately.
REQ-034 delay_cfg=2, out_full held high for 5 cycles during PRELOAD -> no pushes while full; exactly 2 init tokens in total; remain holds.
REQ-035 FORWARD with in_empty/out_full toggled randomly for 1000 cycles -> downstream sequence equals upstream sequence; token_count equals the number of pushes.
REQ-036 token_count preset to 0xFFFF by forwarding 65535 tokens, then one more push -> token_count=0x0000.
REQ-037 stop during PRELOAD (1 of 4 tokens sent), and separately rst_n pulsed low in FORWARD -> IDLE with out_wr=0 at once; a new start with delay_cfg=1 works normally.
